// File: rtl/vector_seq_divider_if.sv
// Request/response bundle for vector_seq_divider.
// DIV_ZERO_FLAG_EN adds the per-element divide-by-zero flag (dz_flag).
interface vector_seq_divider_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [1:0]       precision;
  logic [1:0]       opcode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] result;
  logic             out_valid;
  logic             out_ready;
`ifdef DIV_ZERO_FLAG_EN
  logic [3:0]       dz_flag;

  modport master (output operand_a, operand_b, precision, opcode, in_valid, out_ready,
                  input  in_ready, result, out_valid, dz_flag);
  modport slave  (input  operand_a, operand_b, precision, opcode, in_valid, out_ready,
                  output in_ready, result, out_valid, dz_flag);
`else
  modport master (output operand_a, operand_b, precision, opcode, in_valid, out_ready,
                  input  in_ready, result, out_valid);
  modport slave  (input  operand_a, operand_b, precision, opcode, in_valid, out_ready,
                  output in_ready, result, out_valid);
`endif
endinterface

// File: rtl/vector_seq_divider.sv
// Iterative restoring SIMD divider: 4x8 / 2x16 / 1x32 elements, quotient or remainder.
// Optional feature macro: DIV_ZERO_FLAG_EN (adds bus.dz_flag).
module vsd_sub_lane (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       bin,
  output logic [7:0] d,
  output logic       bout
);
  assign {bout, d} = {1'b0, a} - {1'b0, b} - {8'd0, bin};
endmodule

module vector_seq_divider #(parameter int WIDTH = 32) (
  input  logic clk,
  input  logic rst,
  vector_seq_divider_if.slave bus
);
  localparam int NUM_LANES = WIDTH / 8;

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
  state_t state;

  logic [WIDTH-1:0] a_r, b_r, rem, dvd, dvs, q_fix, r_fix;
  logic [1:0]       prec, op;
  logic [4:0]       cnt;
  logic             fix_step;
  logic [3:0]       sa, sb, sa_n, sb_n, bz, ovf;

  function automatic logic [31:0] expand(input logic [1:0] p, input logic [3:0] m);
    case (p)
      2'b00:   expand = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
      2'b01:   expand = {{16{m[1]}}, {16{m[0]}}};
      default: expand = {32{m[0]}};
    endcase
  endfunction

  function automatic logic [3:0] msbs(input logic [31:0] x, input logic [1:0] p);
    case (p)
      2'b00:   msbs = {x[31], x[23], x[15], x[7]};
      2'b01:   msbs = {2'b00, x[31], x[15]};
      default: msbs = {3'b000, x[31]};
    endcase
  endfunction

  function automatic logic [31:0] neg_sel(input logic [31:0] x, input logic [1:0] p,
                                          input logic [3:0] m);
    logic [31:0] r;
    r = x;
    case (p)
      2'b00:   for (int e = 0; e < 4; e++) if (m[e]) r[e*8 +: 8] = -x[e*8 +: 8];
      2'b01:   for (int e = 0; e < 2; e++) if (m[e]) r[e*16 +: 16] = -x[e*16 +: 16];
      default: if (m[0]) r = -x;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] eq_mask(input logic [31:0] x, input logic [31:0] pat,
                                         input logic [1:0] p);
    logic [3:0] m;
    m = '0;
    case (p)
      2'b00:   for (int e = 0; e < 4; e++) m[e] = (x[e*8 +: 8] == pat[e*8 +: 8]);
      2'b01:   for (int e = 0; e < 2; e++) m[e] = (x[e*16 +: 16] == pat[e*16 +: 16]);
      default: m[0] = (x == pat);
    endcase
    return m;
  endfunction

  // Segmented shift: each element shifts independently; top[k] is the byte holding
  // the MSB of the element that byte k belongs to.
  logic [NUM_LANES-1:0]      start, bout, qbit;
  logic [NUM_LANES-1:0][1:0] top;
  logic [WIDTH-1:0]          rem_sh, dvd_sh, diff, rem_nx, dvd_nx;

  always_comb begin
    case (prec)
      2'b00:   start = 4'b1111;
      2'b01:   start = 4'b0101;
      default: start = 4'b0001;
    endcase
    rem_sh = {rem[WIDTH-2:0], 1'b0};
    dvd_sh = {dvd[WIDTH-2:0], 1'b0};
    for (int k = 0; k < NUM_LANES; k++) begin
      logic [1:0] tk;
      tk = 2'(k);
      case (prec)
        2'b00:   top[k] = tk;
        2'b01:   top[k] = {tk[1], 1'b1};
        default: top[k] = 2'b11;
      endcase
      if (start[k]) begin
        rem_sh[k*8] = dvd[{top[k], 3'b111}];
        dvd_sh[k*8] = 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic bi, bo;
    if (k == 0) begin : g_first
      assign bi = 1'b0;
    end else begin : g_chain
      assign bi = start[k] ? 1'b0 : g_lane[k-1].bo;
    end
    vsd_sub_lane u_sub (.a(rem_sh[k*8 +: 8]), .b(dvs[k*8 +: 8]), .bin(bi),
                        .d(diff[k*8 +: 8]), .bout(bo));
    assign bout[k] = bo;
  end

  // A 1 shifted out of the remainder MSB means the shifted value exceeds any divisor.
  always_comb begin
    rem_nx = rem_sh;
    dvd_nx = dvd_sh;
    for (int k = 0; k < NUM_LANES; k++) begin
      qbit[k] = rem[{top[k], 3'b111}] | ~bout[top[k]];
      if (qbit[k]) rem_nx[k*8 +: 8] = diff[k*8 +: 8];
      if (start[k]) dvd_nx[k*8] = qbit[k];
    end
  end

  logic [31:0] minneg, em_z, em_o, q_fin, r_fin, res_fin;
  always_comb begin
    sa_n = op[0] ? 4'b0 : msbs(a_r, prec);
    sb_n = op[0] ? 4'b0 : msbs(b_r, prec);
    case (prec)
      2'b00:   minneg = 32'h8080_8080;
      2'b01:   minneg = 32'h8000_8000;
      default: minneg = 32'h8000_0000;
    endcase
    bz      = eq_mask(b_r, 32'h0, prec);
    ovf     = op[0] ? 4'b0 : (eq_mask(a_r, minneg, prec) & eq_mask(b_r, 32'hFFFF_FFFF, prec));
    em_z    = expand(prec, bz);
    em_o    = expand(prec, ovf);
    q_fin   = (q_fix & ~em_z & ~em_o) | em_z | (a_r & em_o);
    r_fin   = (r_fix & ~em_z & ~em_o) | (a_r & em_z);
    res_fin = op[1] ? r_fin : q_fin;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
`ifdef DIV_ZERO_FLAG_EN
      bus.dz_flag   <= '0;
`endif
      a_r <= '0; b_r <= '0; rem <= '0; dvd <= '0; dvs <= '0;
      q_fix <= '0; r_fix <= '0; prec <= '0; op <= '0;
      cnt <= '0; fix_step <= 1'b0; sa <= '0; sb <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          a_r          <= bus.operand_a;
          b_r          <= bus.operand_b;
          prec         <= (bus.precision == 2'b11) ? 2'b10 : bus.precision;
          op           <= bus.opcode;
          bus.in_ready <= 1'b0;
          state        <= PREP;
        end
        PREP: begin
          sa    <= sa_n;
          sb    <= sb_n;
          dvd   <= neg_sel(a_r, prec, sa_n);
          dvs   <= neg_sel(b_r, prec, sb_n);
          rem   <= '0;
          cnt   <= (prec == 2'b00) ? 5'd7 : (prec == 2'b01) ? 5'd15 : 5'd31;
          state <= ITER;
        end
        ITER: begin
          rem <= rem_nx;
          dvd <= dvd_nx;
          if (cnt == 5'd0) begin
            fix_step <= 1'b0;
            state    <= FIX;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        // Two cycles: sign-correct, then select and apply special-case overrides.
        FIX: if (!fix_step) begin
          q_fix    <= neg_sel(dvd, prec, sa ^ sb);
          r_fix    <= neg_sel(rem, prec, sa);
          fix_step <= 1'b1;
        end else begin
          bus.result    <= res_fin;
          bus.out_valid <= 1'b1;
`ifdef DIV_ZERO_FLAG_EN
          bus.dz_flag   <= bz;
`endif
          state         <= DONE;
        end
        DONE: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vector_seq_divider.sv
// Directed bench for vector_seq_divider: arithmetic model + hand-computed vectors.
module tb_vector_seq_divider;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vector_seq_divider_if #(.WIDTH(32)) bus();
  vector_seq_divider #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_res;
  logic [3:0]  exp_dz;
  logic        exp_known = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Element-wise reference: plain integer division with sign handling.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] p, input logic [1:0] op,
                                        output logic [3:0] dz);
    int ew;
    longint mask, ua, ub, sa, sb, q, r;
    logic [63:0] acc;
    ew   = (p == 2'b00) ? 8 : (p == 2'b01) ? 16 : 32;
    mask = (longint'(1) << ew) - 1;
    acc  = '0;
    dz   = '0;
    for (int e = 0; e < 32 / ew; e++) begin
      ua = longint'(a >> (e * ew)) & mask;
      ub = longint'(b >> (e * ew)) & mask;
      sa = ua;
      sb = ub;
      if (!op[0]) begin
        if (((ua >> (ew - 1)) & 1) == 1) sa = ua - (mask + 1);
        if (((ub >> (ew - 1)) & 1) == 1) sb = ub - (mask + 1);
      end
      if (ub == 0) begin
        q = mask; r = ua; dz[e] = 1'b1;
      end else if (!op[0] && sa == -((mask + 1) >> 1) && sb == -1) begin
        q = ua; r = 0;
      end else begin
        q = sa / sb; r = sa % sb;
      end
      acc = acc | (64'((op[1] ? r : q) & mask) << (e * ew));
    end
    return acc[31:0];
  endfunction

  always @(negedge clk) begin
    if (!rst && exp_known && bus.out_valid) begin
      chk("cmp_result", bus.result, exp_res);
      chk("cmp_in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
`ifdef DIV_ZERO_FLAG_EN
      chk("cmp_dz_flag", {28'd0, bus.dz_flag}, {28'd0, exp_dz});
`endif
    end
  end

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] p, input logic [1:0] op, input logic [31:0] lit,
                        input logic [3:0] lit_dz, input int stall);
    int lat;
    int n;
    n = (p == 2'b00) ? 8 : (p == 2'b01) ? 16 : 32;
    @(negedge clk);
    chk({name, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    bus.operand_a = a; bus.operand_b = b; bus.precision = p; bus.opcode = op;
    bus.in_valid  = 1'b1;
    exp_res   = model(a, b, p, op, exp_dz);
    exp_known = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.operand_a = 32'hDEAD_BEEF; bus.operand_b = 32'h0BAD_F00D;
    bus.precision = 2'b01; bus.opcode = 2'b10;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (bus.out_valid) break;
    end
    chk({name, "_latency"}, 32'(lat), 32'(n + 3));
    chk({name, "_result"}, bus.result, lit);
`ifdef DIV_ZERO_FLAG_EN
    chk({name, "_dz"}, {28'd0, bus.dz_flag}, {28'd0, lit_dz});
`else
    if (lit_dz === 4'hx) chk({name, "_dz_arg"}, 32'd0, 32'd1);
`endif
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      bus.in_valid  = (s == 1 || s == 3);
      bus.operand_a = 32'h0000_0001; bus.operand_b = 32'h0000_0001;
      @(posedge clk); #1;
      chk({name, "_stall_result"}, bus.result, lit);
      chk({name, "_stall_valid"}, {31'd0, bus.out_valid}, 32'd1);
      chk({name, "_stall_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    exp_known = 1'b0;
    chk({name, "_xfer_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({name, "_xfer_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.operand_a = '0; bus.operand_b = '0; bus.precision = '0; bus.opcode = '0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_result", bus.result, 32'd0);
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
`ifdef DIV_ZERO_FLAG_EN
    chk("reset_dz", {28'd0, bus.dz_flag}, 32'd0);
`endif
    @(negedge clk); rst = 1'b0;

    run_op("divu32",   32'd100, 32'd7, 2'b10, 2'b01, 32'h0000_000E, 4'b0000, 0);
    run_op("remu32",   32'd100, 32'd7, 2'b10, 2'b11, 32'h0000_0002, 4'b0000, 0);
    run_op("div8",     32'h80F9_6407, 32'hFF02_F600, 2'b00, 2'b00, 32'h80FD_F6FF, 4'b0001, 0);
    run_op("rem8",     32'h80F9_6407, 32'hFF02_F600, 2'b00, 2'b10, 32'h00FF_0007, 4'b0001, 0);
    run_op("remu16",   32'hFFFF_0010, 32'h0100_0003, 2'b01, 2'b11, 32'h00FF_0001, 4'b0000, 0);
    run_op("divu16",   32'hFFFF_8000, 32'hFFFF_0003, 2'b01, 2'b01, 32'h0001_2AAA, 4'b0000, 0);
    run_op("divu8",    32'hFFF0_0500, 32'h010F_0700, 2'b00, 2'b01, 32'hFF10_00FF, 4'b0001, 0);
    run_op("div32neg", 32'hFFFF_FF9C, 32'd7, 2'b10, 2'b00, 32'hFFFF_FFF2, 4'b0000, 0);
    run_op("rem32neg", 32'hFFFF_FF9C, 32'd7, 2'b10, 2'b10, 32'hFFFF_FFFE, 4'b0000, 0);
    run_op("div32ovf", 32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 2'b00, 32'h8000_0000, 4'b0000, 0);
    run_op("prec11",   32'd100, 32'd7, 2'b11, 2'b01, 32'h0000_000E, 4'b0000, 0);
    run_op("stall",    32'd100, 32'd7, 2'b10, 2'b01, 32'h0000_000E, 4'b0000, 5);

    // Reset in the middle of ITER discards the in-flight operation.
    @(negedge clk);
    bus.operand_a = 32'd1000; bus.operand_b = 32'd3; bus.precision = 2'b10;
    bus.opcode = 2'b01; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("iter_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_mid_result", bus.result, 32'd0);
    chk("rst_mid_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk); rst = 1'b0;
    run_op("after_rst", 32'd100, 32'd7, 2'b10, 2'b01, 32'h0000_000E, 4'b0000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
